// File: rtl/sipo_pkg.sv
// Shared constants for the SIPO deserializer: FSM encoding and frame length.
// SIPO_PARITY_CHECK_EN adds one trailing even-parity bit to every frame.
package sipo_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

`ifdef SIPO_PARITY_CHECK_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   function automatic int sipo_frame_len(input int width);
      return width + PARITY_BITS;
   endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: shifts a started frame into a registered word.
// Word valid after the frame's last bit edge; held until out_ready, a frame completing
// into an unconsumed word is dropped and sets sticky overrun. Optional: SIPO_PARITY_CHECK_EN.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             start,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int N  = sipo_frame_len(WIDTH);
   localparam int CW = $clog2(WIDTH + 2);

   logic             r_state;
   logic             w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [N-1:0]     r_sr;
   logic [N-1:0]     w_sr_nxt;
   logic [WIDTH-1:0] w_data;
   logic [WIDTH-1:0] r_out;
   logic             r_vld;
   logic             r_ovr;
   logic             w_sample;
   logic             w_last;
   logic             w_busy;

   assign w_sr_nxt = MSB_FIRST ? {r_sr[N-2:0], serial_in} : {serial_in, r_sr[N-1:1]};
   // With parity the parity bit sits at the end opposite the first data bit.
   assign w_data   = MSB_FIRST ? w_sr_nxt[N-1 -: WIDTH] : w_sr_nxt[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_nxt = ST_IDLE;
         default:              w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sample = 1'b0;
      w_last   = 1'b0;
      w_busy   = 1'b0;
      case (r_state)
         ST_IDLE:  w_sample = start;
         ST_SHIFT: begin
            w_sample = 1'b1;
            w_busy   = 1'b1;
            w_last   = (r_cnt == CW'(N - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (w_sample) begin
         r_sr <= w_sr_nxt;
         if (w_last)                 r_cnt <= '0;
         else if (r_state == ST_IDLE) r_cnt <= CW'(1);
         else                        r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out <= '0;
         r_vld <= 1'b0;
         r_ovr <= 1'b0;
      end else if (w_last) begin
         if (!r_vld || out_ready) begin
            r_out <= w_data;
            r_vld <= 1'b1;
         end else begin
            r_ovr <= 1'b1;
         end
      end else if (r_vld && out_ready) begin
         r_vld <= 1'b0;
      end
   end

`ifdef SIPO_PARITY_CHECK_EN
   logic r_perr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              r_perr <= 1'b0;
      else if (w_last && (!r_vld || out_ready)) r_perr <= ^w_sr_nxt;
   end

   assign parity_err = r_perr;
`else
   assign parity_err = 1'b0;
`endif

   assign parallel_out = r_out;
   assign out_valid    = r_vld;
   assign overrun      = r_ovr;
   assign busy         = w_busy;

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver; counterpart of the team's PISO shift register.
- Collects a framed serial bit stream, one bit per clk, into a WIDTH-bit word.
- Presents the word on a registered output with a valid/ready handshake.
- Sits at the receive end of the same single-wire serial link the PISO drives.

Parameters:
- WIDTH, 4, data bits per frame (≥2).
- MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first bit lands in parallel_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
- serial_in  input  1  serial data, sampled on every clk edge while a frame is in progress.
- start  input  1  frame strobe; marks the cycle carrying the first bit.
- parallel_out  output  WIDTH  last completed word (registered).
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word.
- busy  output  1  a frame is being shifted in.
- overrun  output  1  sticky flag: a completed frame was dropped.
- parity_err  output  1  parity result for the word on parallel_out (see Optional Feature).

Behaviour:
- Reset values: parallel_out=0, out_valid=0, busy=0, overrun=0, parity_err=0, shift register=0, bit count=0, FSM=IDLE.
- FSM states: IDLE, SHIFT.
- IDLE, start=1: sample serial_in as bit 0, set count=1, go to SHIFT. busy=1 from the next cycle.
- IDLE, start=0: hold state.
- SHIFT: sample serial_in on every edge and increment count; start is ignored.
- Frame length: N=WIDTH bits, or WIDTH+1 bits with the optional feature.
- Completion: on the edge that samples bit N-1:
  - the assembled word loads into parallel_out;
  - out_valid=1;
  - count=0;
  - FSM returns to IDLE; busy=0 in the following cycle.
- Latency: with start at edge e0, out_valid is visible after edge e0+N-1.
- Back-to-back frames: start may assert in the first IDLE cycle after completion, giving zero dead cycles between frames.
- Bit ordering:
  - MSB_FIRST=1: the shift register shifts left and the new bit enters at LSB.
  - MSB_FIRST=0: the shift register shifts right and the new bit enters at MSB.
- Handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1; out_valid clears after that edge.
  - parallel_out and parity_err stay stable while out_valid=1.
- Simultaneous transfer and completion on the same edge: the new word loads and out_valid stays 1.
- Completion while out_valid=1 and out_ready=0: the new word is discarded, parallel_out is unchanged, and overrun is set.
- overrun clears only on reset.
- Reset mid-frame: the partial word is lost and all state returns to reset values.
- Count register width: $clog2(WIDTH+2).

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - the frame carries WIDTH data bits followed by one even-parity bit;
  - at completion, parity_err = XOR of the data bits and the parity bit, loaded together with parallel_out;
  - parity_err is subject to the same drop rule as parallel_out on overrun.
- Undefined:
  - the frame is WIDTH bits;
  - parity_err is tied to 0;
  - the port is still present.

Decomposition:
- Package sipo_pkg holds:
  - the FSM state encoding localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the frame-length constant computed from WIDTH and SIPO_PARITY_CHECK_EN.
- No sub-module. The shift register, counter and output register are small enough to keep inline in one module.

Test Plan:
- WIDTH=4, MSB_FIRST=1, start with bits 1,0,1,1 on consecutive cycles, out_ready=1 → parallel_out=4'b1011, out_valid=1 for one cycle after the 4th edge, busy high 3 cycles.
- Two back-to-back frames 1011 then 0110, out_ready=1 → two valid pulses, words 4'b1011 then 4'b0110, no overrun.
- Frame 1011 with out_ready=0, then frame 0110 → parallel_out stays 4'b1011, overrun=1. Then out_ready=1 → out_valid drops, overrun stays 1.
- Reset (rst=0) after 2 bits of a frame, then a full frame 1100 → parallel_out=4'b1100 and no residue from the aborted frame.
- MSB_FIRST=0, bits 1,0,1,1 → parallel_out=4'b1101.
- SIPO_PARITY_CHECK_EN defined:
  - bits 1,0,1,1 + parity 1 → word 4'b1011, parity_err=0;
  - bits 1,0,1,1 + parity 0 → parity_err=1.
